serial_mag_comp: RTL and testbench

// Bit-serial N-bit magnitude comparator that builds on the 1-bit comparator stage.
// - Latches two W-bit operands on a start request.
// - Walks the operand pairs MSB-first, one bit pair per clock.
// - Exits early at the first differing bit pair.
// - Reports eq/gt/lt with a one-cycle done pulse to the consumer.

---
 rtl/serial_mag_comp.sv | 99 +++++++++
 tb/tb_serial_mag_comp.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_mag_comp.sv
// rtl/serial_mag_comp.sv - bit-serial MSB-first magnitude comparator with early exit
module serial_mag_comp #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic         busy,
    output logic         done,
    output logic         eq,
    output logic         gt,
    output logic         lt
);

    localparam int IDX_W = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t         state;
    logic [W-1:0]   a_sr;
    logic [W-1:0]   b_sr;
    logic [IDX_W-1:0] idx;
    logic           res_eq;
    logic           res_gt;
    logic           res_lt;

    // The verdict is captured in SHIFT but only published together with done,
    // so eq/gt/lt read all-zero for the whole time a compare is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            idx    <= '0;
            res_eq <= 1'b0;
            res_gt <= 1'b0;
            res_lt <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            eq     <= 1'b0;
            gt     <= 1'b0;
            lt     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sr  <= a_in;
                        b_sr  <= b_in;
                        idx   <= IDX_W'(W - 1);
                        eq    <= 1'b0;
                        gt    <= 1'b0;
                        lt    <= 1'b0;
                        busy  <= 1'b1;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // The operands shift left, so bit idx always sits at the MSB.
                    if (a_sr[W-1] != b_sr[W-1]) begin
                        res_eq <= 1'b0;
                        res_gt <= a_sr[W-1];
                        res_lt <= b_sr[W-1];
                        busy   <= 1'b0;
                        state  <= S_DONE;
                    end else if (idx == '0) begin
                        res_eq <= 1'b1;
                        res_gt <= 1'b0;
                        res_lt <= 1'b0;
                        busy   <= 1'b0;
                        state  <= S_DONE;
                    end else begin
                        a_sr <= a_sr << 1;
                        b_sr <= b_sr << 1;
                        idx  <= idx - IDX_W'(1);
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    eq    <= res_eq;
                    gt    <= res_gt;
                    lt    <= res_lt;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_mag_comp.sv
// tb/tb_serial_mag_comp.sv - self-checking bench for serial_mag_comp (W=8 and W=1)
module tb_serial_mag_comp;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       busy8, done8, eq8, gt8, lt8;
    logic       start1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       busy1, done1, eq1, gt1, lt1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_mag_comp #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8),
        .busy(busy8), .done(done8), .eq(eq8), .gt(gt8), .lt(lt8)
    );

    serial_mag_comp #(.W(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a_in(a1), .b_in(b1),
        .busy(busy1), .done(done1), .eq(eq1), .gt(gt1), .lt(lt1)
    );

    task automatic chk(input bit ok, input string nm, input int act, input int exp_v);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Number of evaluation edges: 1-based MSB position of the first differing bit, or w.
    function automatic int kdiff(input logic [7:0] a, input logic [7:0] b, input int w);
        for (int i = w - 1; i >= 0; i--)
            if (a[i] != b[i]) return w - i;
        return w;
    endfunction

    // Schedule-based model: an accepted start at edge s yields busy after edges s..s+k-1,
    // done plus the verdict after edge s+k+1, and acceptance again from edge s+k+2.
    int  n8, dl8, n1, dl1;
    bit  act8, act1;
    bit  m_busy8, m_done8, m_eq8, m_gt8, m_lt8, r_eq8, r_gt8, r_lt8;
    bit  m_busy1, m_done1, m_eq1, m_gt1, m_lt1, r_eq1, r_gt1, r_lt1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n8 <= 0; dl8 <= 0; act8 <= 0;
            m_busy8 <= 0; m_done8 <= 0; m_eq8 <= 0; m_gt8 <= 0; m_lt8 <= 0;
            r_eq8 <= 0; r_gt8 <= 0; r_lt8 <= 0;
        end else begin
            n8 <= n8 + 1;
            m_done8 <= act8 && (n8 + 1 == dl8);
            if (act8) begin
                if (n8 + 1 == dl8 - 1) m_busy8 <= 0;
                if (n8 + 1 == dl8) begin
                    act8 <= 0;
                    m_eq8 <= r_eq8; m_gt8 <= r_gt8; m_lt8 <= r_lt8;
                end
            end else if (start8) begin
                act8 <= 1;
                dl8 <= n8 + 1 + kdiff(a8, b8, 8) + 1;
                r_eq8 <= (a8 == b8); r_gt8 <= (a8 > b8); r_lt8 <= (a8 < b8);
                m_eq8 <= 0; m_gt8 <= 0; m_lt8 <= 0;
                m_busy8 <= 1;
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n1 <= 0; dl1 <= 0; act1 <= 0;
            m_busy1 <= 0; m_done1 <= 0; m_eq1 <= 0; m_gt1 <= 0; m_lt1 <= 0;
            r_eq1 <= 0; r_gt1 <= 0; r_lt1 <= 0;
        end else begin
            n1 <= n1 + 1;
            m_done1 <= act1 && (n1 + 1 == dl1);
            if (act1) begin
                if (n1 + 1 == dl1 - 1) m_busy1 <= 0;
                if (n1 + 1 == dl1) begin
                    act1 <= 0;
                    m_eq1 <= r_eq1; m_gt1 <= r_gt1; m_lt1 <= r_lt1;
                end
            end else if (start1) begin
                act1 <= 1;
                dl1 <= n1 + 1 + kdiff({7'b0, a1}, {7'b0, b1}, 1) + 1;
                r_eq1 <= (a1 == b1); r_gt1 <= (a1 > b1); r_lt1 <= (a1 < b1);
                m_eq1 <= 0; m_gt1 <= 0; m_lt1 <= 0;
                m_busy1 <= 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk(busy8 === m_busy8, "busy8", busy8, m_busy8);
            chk(done8 === m_done8, "done8", done8, m_done8);
            chk(eq8 === m_eq8, "eq8", eq8, m_eq8);
            chk(gt8 === m_gt8, "gt8", gt8, m_gt8);
            chk(lt8 === m_lt8, "lt8", lt8, m_lt8);
            chk(!(busy8 && done8), "busy8_done8_overlap", {busy8, done8}, 0);
            if (done8) chk($onehot({eq8, gt8, lt8}), "onehot8", {eq8, gt8, lt8}, 1);
            chk(busy1 === m_busy1, "busy1", busy1, m_busy1);
            chk(done1 === m_done1, "done1", done1, m_done1);
            chk(eq1 === m_eq1, "eq1", eq1, m_eq1);
            chk(gt1 === m_gt1, "gt1", gt1, m_gt1);
            chk(lt1 === m_lt1, "lt1", lt1, m_lt1);
            chk(!(busy1 && done1), "busy1_done1_overlap", {busy1, done1}, 0);
        end
    end

    // Start one compare on the W=8 instance, scramble operands after E0, and pin
    // latency (edges from E0 to the done edge) and the verdict {eq,gt,lt}.
    task automatic go8(input logic [7:0] a, input logic [7:0] b, input int lat_exp,
                       input logic [2:0] res_exp, input string nm);
        int lat;
        bit seen;
        @(negedge clk); start8 = 1; a8 = a; b8 = b;
        @(negedge clk); start8 = 0; a8 = 8'($urandom); b8 = 8'($urandom);
        lat = 0; seen = 0;
        for (int i = 1; i <= 12 && !seen; i++) begin
            @(negedge clk);
            lat = i;
            if (done8) seen = 1;
        end
        chk(seen, {nm, "_done_seen"}, seen, 1);
        chk(lat == lat_exp, {nm, "_latency"}, lat, lat_exp);
        chk({eq8, gt8, lt8} == res_exp, {nm, "_result"}, {eq8, gt8, lt8}, res_exp);
        @(negedge clk);
        chk(done8 == 0, {nm, "_done_width"}, done8, 0);
    endtask

    task automatic go1(input logic a, input logic b, input logic [2:0] res_exp, input string nm);
        int lat;
        bit seen;
        @(negedge clk); start1 = 1; a1 = a; b1 = b;
        @(negedge clk); start1 = 0; a1 = ~a; b1 = ~b;
        lat = 0; seen = 0;
        for (int i = 1; i <= 6 && !seen; i++) begin
            @(negedge clk);
            lat = i;
            if (done1) seen = 1;
        end
        chk(seen, {nm, "_done_seen"}, seen, 1);
        chk(lat == 2, {nm, "_latency"}, lat, 2);
        chk({eq1, gt1, lt1} == res_exp, {nm, "_result"}, {eq1, gt1, lt1}, res_exp);
        @(negedge clk);
        chk(done1 == 0, {nm, "_done_width"}, done1, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        chk({busy8, done8, eq8, gt8, lt8} == 5'b0, "reset8_outputs", {busy8, done8, eq8, gt8, lt8}, 0);
        chk({busy1, done1, eq1, gt1, lt1} == 5'b0, "reset1_outputs", {busy1, done1, eq1, gt1, lt1}, 0);

        go8(8'hA5, 8'hA5, 9, 3'b100, "t1_equal");
        go8(8'h80, 8'h7F, 2, 3'b010, "t2_msb");
        go8(8'h12, 8'h13, 9, 3'b001, "t3_lsb");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk({done8, eq8, gt8, lt8} == 4'b0001, "t3_hold", {done8, eq8, gt8, lt8}, 1);
        end

        // Second request lands at E1 while busy and must be ignored.
        @(negedge clk); start8 = 1; a8 = 8'h00; b8 = 8'hFF;
        @(negedge clk); a8 = 8'hFF; b8 = 8'h00;
        @(negedge clk); start8 = 0;
        @(negedge clk);
        chk({done8, eq8, gt8, lt8} == 4'b1001, "t4_ignored", {done8, eq8, gt8, lt8}, 9);
        go8(8'hFF, 8'h00, 2, 3'b010, "t4_fresh");

        // Asynchronous reset in the middle of the cycle after E3.
        @(negedge clk); start8 = 1; a8 = 8'h0F; b8 = 8'h0F;
        @(negedge clk); start8 = 0;
        repeat (3) @(posedge clk);
        #2 rst = 1;
        #1 chk({busy8, done8, eq8, gt8, lt8} == 5'b0, "t5_async_reset", {busy8, done8, eq8, gt8, lt8}, 0);
        @(negedge clk);
        chk(busy8 == 0, "t5_held_idle", busy8, 0);
        rst = 0;
        go8(8'h01, 8'h02, 8, 3'b001, "t5_after_reset");

        go1(1'b1, 1'b0, 3'b010, "t6_w1_gt");
        go1(1'b0, 1'b0, 3'b100, "t6_w1_eq");
        go1(1'b0, 1'b1, 3'b001, "t6_w1_lt");

        // Random traffic, including long runs of start held high.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            start8 = ($urandom_range(0, 3) != 0);
            a8 = 8'($urandom);
            case ($urandom_range(0, 2))
                0: b8 = a8;
                1: b8 = a8 ^ (8'h01 << $urandom_range(0, 7));
                default: b8 = 8'($urandom);
            endcase
            start1 = ($urandom_range(0, 2) != 0);
            a1 = 1'($urandom);
            b1 = 1'($urandom);
        end
        @(negedge clk); start8 = 0; start1 = 0;
        repeat (12) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
